tri_bus_ctrl: RTL and testbench



---
 rtl/tri_bus_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_tri_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_ctrl.sv
// Owner end of a shared tri-state bus: round-robin arbitration, bounded hold, turnaround gaps, readback.
// Optional sticky contention detector enabled by defining TRI_BUS_CONTENTION_DET_EN.
module tri_bus_ctrl #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         din,
    output logic [N-1:0]           grant,
    inout  tri   [W-1:0]           bus,
    output logic [W-1:0]           rd_data,
    output logic                   rd_valid,
    output logic [$clog2(N)-1:0]   rd_src,
    output logic                   busy
`ifdef TRI_BUS_CONTENTION_DET_EN
    ,
    output logic                   contention
`endif
);

    localparam int OW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [1:0] TURN_L = 2'(TURN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_ptr;
    logic [HW-1:0]   r_hold;
    logic [1:0]      r_turn;
    logic [N-1:0]    r_grant;
    logic [W-1:0]    r_rd_data;
    logic            r_rd_valid;
    logic [OW-1:0]   r_rd_src;

    state_t          w_state_next;
    logic [OW-1:0]   w_owner_next;
    logic [OW-1:0]   w_ptr_next;
    logic [HW-1:0]   w_hold_next;
    logic [1:0]      w_turn_next;
    logic [N-1:0]    w_grant_next;
    logic            w_start;
    logic [OW-1:0]   w_next_ptr;
    logic [OW-1:0]   w_arb_base;
    logic [OW-1:0]   w_scan_idx;
    logic [OW-1:0]   w_arb_idx;
    logic            w_arb_found;
    logic [W-1:0]    w_drv;
    logic [W-1:0]    w_din_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_din
        assign w_din_arr[gi] = din[gi*W +: W];
    end

    assign w_drv = w_din_arr[r_owner];
    assign bus   = (r_state == S_GRANT) ? w_drv : {W{1'bz}};

    assign w_next_ptr = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;
    // On release the pointer update and a same-cycle re-arbitration must agree, so scan from owner+1.
    assign w_arb_base = (r_state == S_GRANT) ? w_next_ptr : r_ptr;

    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_scan_idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_scan_idx = OW'((int'(w_arb_base) + k) % N);
            if (req[w_scan_idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_hold_next  = r_hold;
        w_turn_next  = r_turn;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: w_start = w_arb_found;
            S_GRANT: begin
                if (req[r_owner] && (r_hold < HW'(MAX_HOLD))) begin
                    w_hold_next = r_hold + 1'b1;
                end else begin
                    w_ptr_next  = w_next_ptr;
                    w_hold_next = '0;
                    if (TURN > 0) begin
                        w_state_next = S_TURN;
                        w_turn_next  = 2'd1;
                    end else begin
                        w_state_next = S_IDLE;
                        w_start      = w_arb_found;
                    end
                end
            end
            S_TURN: begin
                // Arbitrating in the last gap cycle keeps the Z gap at exactly TURN cycles.
                if (r_turn >= TURN_L) begin
                    w_state_next = S_IDLE;
                    w_turn_next  = 2'd0;
                    w_start      = w_arb_found;
                end else begin
                    w_turn_next = r_turn + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_start) begin
            w_state_next = S_GRANT;
            w_owner_next = w_arb_idx;
            w_hold_next  = HW'(1);
        end
        w_grant_next = (w_state_next == S_GRANT) ? (N'(1) << w_owner_next) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_hold     <= '0;
            r_turn     <= '0;
            r_grant    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_src   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_ptr      <= w_ptr_next;
            r_hold     <= w_hold_next;
            r_turn     <= w_turn_next;
            r_grant    <= w_grant_next;
            r_rd_valid <= (r_state == S_GRANT);
            if (r_state == S_GRANT) begin
                r_rd_data <= bus;
                r_rd_src  <= r_owner;
            end
        end
    end

    assign grant    = r_grant;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_src   = r_rd_src;
    assign busy     = (r_state == S_GRANT) || (r_state == S_TURN);

`ifdef TRI_BUS_CONTENTION_DET_EN
    logic [W-1:0] r_drv;
    logic         r_contention;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drv        <= '0;
            r_contention <= 1'b0;
        end else begin
            if (r_state == S_GRANT) begin
                r_drv <= w_drv;
            end
            // Case inequality so an X/Z readback also flags in simulation.
            if (r_rd_valid && (r_rd_data !== r_drv)) begin
                r_contention <= 1'b1;
            end
        end
    end

    assign contention = r_contention;
`endif

endmodule

// File: tb/tb_tri_bus_ctrl.sv
// Bench for tri_bus_ctrl: constant vector table, hand sequences and random traffic vs. a reference model.
// Two instances run in lockstep: TURN=1/MAX_HOLD=16 and TURN=0/MAX_HOLD=4.
module tb_tri_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] din = '0;

    logic [3:0]  grant_a, grant_b;
    tri   [7:0]  bus_a, bus_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic [1:0]  rd_src_a, rd_src_b;
    logic        busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

`ifdef TRI_BUS_CONTENTION_DET_EN
    logic       contention_a, contention_b;
    logic       tb_en = 1'b0;
    logic [7:0] tb_val = '0;
    assign bus_a = tb_en ? tb_val : 8'bzzzzzzzz;
`endif

    always #5 clk = ~clk;

    tri_bus_ctrl #(.N(4), .W(8), .TURN(1), .MAX_HOLD(16)) dut_a (
        .clk(clk), .reset(reset), .req(req), .din(din), .grant(grant_a), .bus(bus_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_src(rd_src_a), .busy(busy_a)
`ifdef TRI_BUS_CONTENTION_DET_EN
        , .contention(contention_a)
`endif
    );

    tri_bus_ctrl #(.N(4), .W(8), .TURN(0), .MAX_HOLD(4)) dut_b (
        .clk(clk), .reset(reset), .req(req), .din(din), .grant(grant_b), .bus(bus_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_src(rd_src_b), .busy(busy_b)
`ifdef TRI_BUS_CONTENTION_DET_EN
        , .contention(contention_b)
`endif
    );

    // Reference model: who owns the bus, how long it has driven, Z cycles still owed, next priority.
    int         m_owner [2];
    int         m_run   [2];
    int         m_gap   [2];
    int         m_ptr   [2];
    int         m_rdv   [2];
    int         m_rds   [2];
    logic [7:0] m_rdd   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    task automatic model_step(input int i, input logic rst_i, input logic [3:0] r, input logic [31:0] d);
        int turn, mx, p;
        bit arb;
        turn = (i == 0) ? 1 : 0;
        mx   = (i == 0) ? 16 : 4;
        arb  = 1'b0;
        if (rst_i) begin
            m_owner[i] = -1; m_run[i] = 0; m_gap[i] = 0; m_ptr[i] = 0;
            m_rdv[i] = 0; m_rds[i] = 0; m_rdd[i] = '0;
        end else begin
            if (m_owner[i] >= 0) begin
                m_rdv[i] = 1;
                m_rdd[i] = d[m_owner[i]*8 +: 8];
                m_rds[i] = m_owner[i];
                if (r[m_owner[i]] && m_run[i] < mx) begin
                    m_run[i]++;
                end else begin
                    m_ptr[i]   = (m_owner[i] + 1) % 4;
                    m_owner[i] = -1;
                    m_gap[i]   = turn;
                    arb        = (turn == 0);
                end
            end else begin
                m_rdv[i] = 0;
                if (m_gap[i] > 0) begin
                    m_gap[i]--;
                    arb = (m_gap[i] == 0);
                end else begin
                    arb = 1'b1;
                end
            end
            if (arb) begin
                p = pick(r, m_ptr[i]);
                if (p >= 0) begin
                    m_owner[i] = p;
                    m_run[i]   = 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int i, input logic [3:0] g, input logic v, input logic [7:0] dd,
                             input logic [1:0] s, input logic b, input logic [7:0] bv, input logic [31:0] d);
        logic [3:0] eg;
        eg = (m_owner[i] >= 0) ? 4'(1 << m_owner[i]) : 4'b0000;
        chk($sformatf("dut%0d grant", i), 32'(g), 32'(eg));
        chk($sformatf("dut%0d rd_valid", i), 32'(v), 32'(m_rdv[i]));
        chk($sformatf("dut%0d rd_data", i), 32'(dd), 32'(m_rdd[i]));
        chk($sformatf("dut%0d rd_src", i), 32'(s), 32'(m_rds[i]));
        chk($sformatf("dut%0d busy", i), 32'(b), 32'((m_owner[i] >= 0) || (m_gap[i] > 0)));
        if (m_owner[i] >= 0) chk($sformatf("dut%0d bus", i), 32'(bv), 32'(d[m_owner[i]*8 +: 8]));
    endtask

    task automatic cycle(input logic rst_i, input logic [3:0] r, input logic [31:0] d, input bit do_chk);
        reset = rst_i;
        req   = r;
        din   = d;
        @(posedge clk);
        #1;
        model_step(0, rst_i, r, d);
        model_step(1, rst_i, r, d);
        if (do_chk) begin
            check_dut(0, grant_a, rd_valid_a, rd_data_a, rd_src_a, busy_a, bus_a, d);
            check_dut(1, grant_b, rd_valid_b, rd_data_b, rd_src_b, busy_b, bus_b, d);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic       vld;
        logic [7:0] data;
        logic [1:0] src;
        logic       busy;
    } vec_t;

    initial begin
        vec_t       tbl [14];
        logic [3:0] r;
        logic [31:0] d;
        int         cnt_g, cnt_v;
        logic [3:0] g17, g18, gb2, gb3;

        // Expectations for dut_a (TURN=1) with din[0..3] = A5,22,33,44.
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'hA5, 2'd0, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 4'b1010, 4'b0010, 1'b0, 8'hA5, 2'd0, 1'b1};
        tbl[8]  = '{1'b0, 4'b1000, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 4'b1000, 4'b1000, 1'b0, 8'h22, 2'd1, 1'b1};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'h44, 2'd3, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h44, 2'd3, 1'b0};
        tbl[12] = '{1'b1, 4'b0100, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 4'b0100, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b1};

        for (int t = 0; t < 14; t++) begin
            cycle(tbl[t].rst, tbl[t].req, 32'h443322A5, 1'b1);
            chk($sformatf("tbl%0d grant", t), 32'(grant_a), 32'(tbl[t].grant));
            chk($sformatf("tbl%0d rd_valid", t), 32'(rd_valid_a), 32'(tbl[t].vld));
            chk($sformatf("tbl%0d rd_data", t), 32'(rd_data_a), 32'(tbl[t].data));
            chk($sformatf("tbl%0d rd_src", t), 32'(rd_src_a), 32'(tbl[t].src));
            chk($sformatf("tbl%0d busy", t), 32'(busy_a), 32'(tbl[t].busy));
        end

        // Hold limit: a lone requester gets 16 cycles, one Z cycle, then the bus again.
        cycle(1'b1, 4'b0000, 32'h11223344, 1'b1);
        cnt_g = 0; cnt_v = 0; g17 = '0; g18 = '0;
        for (int c = 1; c <= 40; c++) begin
            cycle(1'b0, 4'b0100, 32'h11223344 + 32'(c), 1'b1);
            if (c <= 17 && grant_a[2]) cnt_g++;
            if (c >= 2 && c <= 17 && rd_valid_a) cnt_v++;
            if (c == 17) g17 = grant_a;
            if (c == 18) g18 = grant_a;
        end
        chk("hold grant cycles", 32'(cnt_g), 32'd16);
        chk("hold rd_valid count", 32'(cnt_v), 32'd16);
        chk("hold gap grant", 32'(g17), 32'b0000);
        chk("hold regrant", 32'(g18), 32'b0100);

        // Round robin between sources 1 and 3.
        cycle(1'b1, 4'b0000, 32'h0, 1'b1);
        g18 = '0;
        for (int c = 1; c <= 40; c++) begin
            cycle(1'b0, 4'b1010, $urandom, 1'b1);
            chk("rr exclusive", 32'(grant_a[1] & grant_a[3]), 32'd0);
            if (c == 1) chk("rr first owner", 32'(grant_a), 32'b0010);
            if (c == 18) g18 = grant_a;
        end
        chk("rr second owner", 32'(g18), 32'b1000);

        // Reset during the 5th drive cycle, then arbitration restarts at source 0.
        cycle(1'b1, 4'b0000, 32'h0, 1'b1);
        for (int c = 1; c <= 4; c++) cycle(1'b0, 4'b1001, 32'hDEADBEEF, 1'b1);
        cycle(1'b1, 4'b1001, 32'hDEADBEEF, 1'b1);
        chk("midreset grant", 32'(grant_a), 32'd0);
        chk("midreset rd_valid", 32'(rd_valid_a), 32'd0);
        chk("midreset busy", 32'(busy_a), 32'd0);
        cycle(1'b0, 4'b1111, 32'hDEADBEEF, 1'b1);
        chk("postreset owner", 32'(grant_a), 32'b0001);

        // TURN=0 instance: back-to-back handover with no gap.
        cycle(1'b1, 4'b0000, 32'h0, 1'b1);
        cycle(1'b0, 4'b0011, 32'h55667788, 1'b1);
        cycle(1'b0, 4'b0011, 32'h55667788, 1'b1);
        gb2 = grant_b;
        cycle(1'b0, 4'b0010, 32'h55667788, 1'b1);
        gb3 = grant_b;
        chk("turn0 first", 32'(gb2), 32'b0001);
        chk("turn0 handover", 32'(gb3), 32'b0010);

        // Random traffic against the model.
        cycle(1'b1, 4'b0000, 32'h0, 1'b1);
        r = '0;
        for (int c = 0; c < 500; c++) begin
            r = r ^ (4'($urandom) & 4'($urandom));
            d = $urandom;
            cycle(($urandom_range(0, 99) == 0), r, d, 1'b1);
        end

`ifdef TRI_BUS_CONTENTION_DET_EN
        cycle(1'b1, 4'b0000, 32'h0, 1'b1);
        chk("contention after reset", 32'(contention_a), 32'd0);
        tb_val = 8'h0F;
        tb_en  = 1'b1;
        for (int c = 0; c < 4; c++) cycle(1'b0, 4'b0001, 32'h000000F0, 1'b0);
        tb_en = 1'b0;
        for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0000, 32'h000000F0, 1'b0);
        chk("contention set", 32'(contention_a), 32'd1);
        chk("contention clean peer", 32'(contention_b), 32'd0);
        for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0000, 32'h0, 1'b0);
        chk("contention sticky", 32'(contention_a), 32'd1);
        cycle(1'b1, 4'b0000, 32'h0, 1'b1);
        chk("contention cleared", 32'(contention_a), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
